// File: rtl/cia_pkg.sv
// Shared types for the CIA interrupt control register: chip model selector
// and the packed ICR read view.
package cia;

    typedef enum logic {
        MOS6526 = 1'b0,
        MOS8521 = 1'b1
    } model_t;

    typedef struct packed {
        logic       ir;
        logic [1:0] unused;
        logic [4:0] flags;
    } icr_t;

    localparam logic [3:0] ICR_ADDR_DEFAULT = 4'hD;

endpackage

// File: rtl/cia_interrupt_if.sv
// CPU-side register bus of the CIA interrupt block: strobed read/write
// controls, address and write data, plus the combinational ICR read view.
interface cia_interrupt_if;

    logic      rd;
    logic      we;
    logic [3:0] addr;
    logic [7:0] data;
    cia::icr_t regs;

    modport master (output rd, we, addr, data, input regs);
    modport slave  (input rd, we, addr, data, output regs);

endinterface

// File: rtl/cia_interrupt.sv
// CIA interrupt control register: source flags, mask, IR bit and irq_n with
// model-dependent latency. Define CIA_ICR_DEBUG_EN to expose the mask register.
module cia_interrupt
    import cia::*;
#(
    parameter logic [3:0] ICR_ADDR = ICR_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             res_n,
    input  model_t           model,
    input  logic             phi2_up,
    input  logic             phi2_dn,
    cia_interrupt_if.slave   bus,
    input  logic [4:0]       sources,
    output logic             irq_n
`ifdef CIA_ICR_DEBUG_EN
    ,
    output logic [4:0]       icr_mask
`endif
);

    logic [4:0] flags_q, flags_d;
    logic [4:0] mask_q, mask_d;
    logic       ir_q, ir_d;
    logic       dly_q, dly_d;
    logic       irq_n_q, irq_n_d;
    logic       icr_hit;
    logic       clr;
    logic       wr;
    logic       unused_inputs;

    // phi2_up and data[6:5] carry no meaning for the ICR
    assign unused_inputs = ^{phi2_up, bus.data[6:5]};

    always_comb begin
        icr_hit = (bus.addr == ICR_ADDR);
        clr     = phi2_dn && bus.rd && icr_hit;
        wr      = phi2_dn && bus.we && icr_hit;
        flags_d = flags_q;
        mask_d  = mask_q;
        ir_d    = ir_q;
        dly_d   = dly_q;
        irq_n_d = irq_n_q;
        if (phi2_dn) begin
            // A new event wins over the read-clear so it is never lost
            flags_d = (clr ? 5'b0 : flags_q) | sources;
            if (wr) begin
                mask_d = bus.data[7] ? (mask_q | bus.data[4:0])
                                     : (mask_q & ~bus.data[4:0]);
            end
            if (|(flags_d & mask_d)) begin
                ir_d = 1'b1;
            end else if (clr) begin
                ir_d = 1'b0;
            end
            dly_d = ir_d;
            // The 6526 drives irq_n one PHI2 cycle behind ir; a read releases at once
            if (model == MOS8521) begin
                irq_n_d = ~ir_d;
            end else begin
                irq_n_d = clr ? 1'b1 : ~dly_q;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            flags_q <= '0;
            mask_q  <= '0;
            ir_q    <= 1'b0;
            dly_q   <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            flags_q <= flags_d;
            mask_q  <= mask_d;
            ir_q    <= ir_d;
            dly_q   <= dly_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign bus.regs = {ir_q, 2'b00, flags_q};
    assign irq_n    = irq_n_q;

`ifdef CIA_ICR_DEBUG_EN
    assign icr_mask = mask_q;
`endif

endmodule

// File: tb/tb_cia_interrupt.sv
// Scoreboard bench for cia_interrupt: each PHI2 strobe pushes the expected
// {regs, irq_n}, which is popped after the strobe and after a dummy clk edge.
module tb_cia_interrupt;
    import cia::*;

    typedef struct {
        string      tag;
        logic [8:0] expected;
    } sb_entry_t;

    localparam logic [3:0] ICR = 4'hD;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       phi2_up = 1'b0;
    logic       phi2_dn = 1'b0;
    model_t     model = MOS8521;
    logic [4:0] sources = 5'b0;
    logic       irq_n;
`ifdef CIA_ICR_DEBUG_EN
    logic [4:0] icr_mask;
`endif

    cia_interrupt_if bus();

    sb_entry_t  scoreboard[$];
    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] lastRegs = 8'h00;

    cia_interrupt #(.ICR_ADDR(ICR)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .model   (model),
        .phi2_up (phi2_up),
        .phi2_dn (phi2_dn),
        .bus     (bus),
        .sources (sources),
        .irq_n   (irq_n)
`ifdef CIA_ICR_DEBUG_EN
        ,
        .icr_mask(icr_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        bus.rd   = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 4'h0;
        bus.data = 8'h00;
        sources  = 5'b0;
        phi2_dn  = 1'b0;
        phi2_up  = 1'b0;
    endtask

    task automatic popAndCheck();
        sb_entry_t e;
        if (scoreboard.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, {bus.regs, irq_n}, e.expected);
        end
    endtask

    // One PHI2 strobe, then a clk edge with busy inputs but no strobe
    task automatic applyStimulus(input string tag, input logic rdIn, input logic weIn,
                                 input logic [3:0] addrIn, input logic [7:0] dataIn,
                                 input logic [4:0] srcIn, input logic [7:0] expRegs,
                                 input logic expIrqN);
        sb_entry_t e;
        @(negedge clk);
        bus.rd   = rdIn;
        bus.we   = weIn;
        bus.addr = addrIn;
        bus.data = dataIn;
        sources  = srcIn;
        phi2_dn  = 1'b1;
        e.tag = tag;
        e.expected = {expRegs, expIrqN};
        scoreboard.push_back(e);
        e.tag = {tag, "_idle"};
        scoreboard.push_back(e);
        #1;
        if (rdIn && addrIn == ICR)
            checkOutput({tag, "_pre"}, {1'b0, bus.regs}, {1'b0, lastRegs});
        @(posedge clk);
        #1;
        idleInputs();
        popAndCheck();
        @(negedge clk);
        bus.rd   = 1'b1;
        bus.we   = 1'b1;
        bus.addr = ICR;
        bus.data = 8'hFF;
        sources  = 5'h1F;
        phi2_up  = 1'b1;
        @(posedge clk);
        #1;
        idleInputs();
        popAndCheck();
        lastRegs = expRegs;
    endtask

    task automatic doReset(input model_t m);
        @(negedge clk);
        res_n = 1'b0;
        model = m;
        #1;
        checkOutput("reset", {bus.regs, irq_n}, 9'h001);
        @(negedge clk);
        res_n = 1'b1;
        lastRegs = 8'h00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();
        repeat (2) @(posedge clk);

        // MOS8521: irq_n tracks ir in the same cycle
        doReset(MOS8521);
        applyStimulus("rd_after_reset", 1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("wr_81",          0, 1, ICR, 8'h81, 5'b00000, 8'h00, 1);
        applyStimulus("ta_event",       0, 0, ICR, 8'h00, 5'b00001, 8'h81, 0);
        applyStimulus("rd_clear",       1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("wr_01_unmask",   0, 1, ICR, 8'h01, 5'b00000, 8'h00, 1);
        applyStimulus("tb_masked",      0, 0, ICR, 8'h00, 5'b00010, 8'h02, 1);
        applyStimulus("wr_82_late",     0, 1, ICR, 8'h82, 5'b00000, 8'h82, 0);
        applyStimulus("rd_clear2",      1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("wr_90",          0, 1, ICR, 8'h90, 5'b00000, 8'h00, 1);
        applyStimulus("rd_with_flag",   1, 0, ICR, 8'h00, 5'b10000, 8'h90, 0);
        applyStimulus("rd_clear3",      1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("tb_event",       0, 0, ICR, 8'h00, 5'b00010, 8'h82, 0);
        applyStimulus("wr_02_keep_ir",  0, 1, ICR, 8'h02, 5'b00000, 8'h82, 0);
        applyStimulus("rd_clear4",      1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("ta_unmasked",    0, 0, ICR, 8'h00, 5'b00001, 8'h01, 1);
        applyStimulus("rd_other_addr",  1, 0, 4'h0, 8'h00, 5'b00000, 8'h01, 1);
        applyStimulus("wr_other_addr",  0, 1, 4'h0, 8'h81, 5'b00000, 8'h01, 1);
        applyStimulus("wr_81_late",     0, 1, ICR, 8'h81, 5'b00000, 8'h81, 0);
        applyStimulus("rd_clear5",      1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("wr_9F",          0, 1, ICR, 8'h9F, 5'b00000, 8'h00, 1);
        applyStimulus("wr_01_clear",    0, 1, ICR, 8'h01, 5'b00000, 8'h00, 1);
`ifdef CIA_ICR_DEBUG_EN
        checkOutput("mask_debug", {4'b0, icr_mask}, 9'h01E);
`endif
        applyStimulus("ta_now_masked",  0, 0, ICR, 8'h00, 5'b00001, 8'h01, 1);
        applyStimulus("tod_event",      0, 0, ICR, 8'h00, 5'b00100, 8'h85, 0);

        // Reset in the middle of a strobed read+write must drop both
        @(negedge clk);
        bus.rd   = 1'b1;
        bus.we   = 1'b1;
        bus.addr = ICR;
        bus.data = 8'h9F;
        phi2_dn  = 1'b1;
        #2;
        res_n = 1'b0;
        #1;
        checkOutput("mid_reset_async", {bus.regs, irq_n}, 9'h001);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_edge", {bus.regs, irq_n}, 9'h001);
        idleInputs();
        @(negedge clk);
        res_n = 1'b1;
        lastRegs = 8'h00;
`ifdef CIA_ICR_DEBUG_EN
        checkOutput("mask_after_reset", {4'b0, icr_mask}, 9'h000);
`endif
        applyStimulus("tod_after_reset", 0, 0, ICR, 8'h00, 5'b00100, 8'h04, 1);

        // MOS6526: irq_n falls one strobe after ir
        doReset(MOS6526);
        applyStimulus("m6_wr_81",       0, 1, ICR, 8'h81, 5'b00000, 8'h00, 1);
        applyStimulus("m6_ta_event",    0, 0, ICR, 8'h00, 5'b00001, 8'h81, 1);
        applyStimulus("m6_delayed",     0, 0, ICR, 8'h00, 5'b00000, 8'h81, 0);
        applyStimulus("m6_rd_clear",    1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("m6_after_clear", 0, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);
        applyStimulus("m6_wr_01",       0, 1, ICR, 8'h01, 5'b00000, 8'h00, 1);
        applyStimulus("m6_tb_masked",   0, 0, ICR, 8'h00, 5'b00010, 8'h02, 1);
        applyStimulus("m6_wr_82",       0, 1, ICR, 8'h82, 5'b00000, 8'h82, 1);
        applyStimulus("m6_wr_82_delay", 0, 0, ICR, 8'h00, 5'b00000, 8'h82, 0);
        applyStimulus("m6_rd_clear2",   1, 0, ICR, 8'h00, 5'b00000, 8'h00, 1);

        if (scoreboard.size() != 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cia_interrupt.md
CIA_INTERRUPT -- requirements
Module: cia_interrupt

Interface
REQ-001 Parameter ICR_ADDR, default 4'hD: register address decoded for ICR access.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 res_n  in  1  asynchronous active-low reset.
REQ-004 model  in  cia::model_t  chip model, MOS6526 or MOS8521; treated as static.
REQ-005 phi2_up  in  1  one-clk strobe marking PHI2 rising edge; accepted but unused.
REQ-006 phi2_dn  in  1  one-clk strobe marking PHI2 falling edge; the only update instant.
REQ-007 rd  in  1  bus read enable, valid while phi2_dn is sampled.
REQ-008 we  in  1  bus write enable, valid while phi2_dn is sampled.
REQ-009 addr  in  4  register address.
REQ-010 data  in  8  write data.
REQ-011 sources  in  5  event pulses {flag, sp, tod, tb, ta}, bit 0 = ta.
REQ-012 regs  out  cia::icr_t (8)  read view {ir, 2'b00, flags[4:0]}.
REQ-013 irq_n  out  1  active-low interrupt request, registered.

Function
REQ-014 Cycle n SHALL mean the phi2_dn strobe n; no state SHALL change on clk edges without phi2_dn, except reset.
REQ-015 At cycle n, flags SHALL become (clr ? 5'b0 : flags) | sources, where clr = rd && addr==ICR_ADDR.
REQ-016 A source event coinciding with an ICR read SHALL survive: its flag reads 1 afterwards.
REQ-017 Write at cycle n (we && addr==ICR_ADDR): data[7]=1 SHALL set the mask bits selected by data[4:0]; data[7]=0 SHALL clear them; data[6:5] SHALL be ignored.
REQ-018 The write SHALL leave flags unchanged.
REQ-019 Interrupt condition c = |(flags_next & mask_next), both evaluated at cycle n.
REQ-020 ir SHALL become 1 at cycle n when c=1.
REQ-021 ir SHALL be cleared only by an ICR read, at the end of that read cycle.
REQ-022 A read coinciding with a new enabled event SHALL leave ir=1.
REQ-023 MOS8521: irq_n SHALL equal ~ir, updated at the same cycle n.
REQ-024 MOS6526: irq_n SHALL fall at cycle n+1, via one delay stage.
REQ-025 An ICR read SHALL release irq_n at the end of that read cycle in both models, and SHALL clear the delay stage.
REQ-026 Setting a mask bit whose flag is already set SHALL assert ir at that cycle; irq_n follows with the model latency of REQ-023/REQ-024.
REQ-027 Clearing a mask bit SHALL NOT clear ir or release irq_n.
REQ-028 regs SHALL be combinational from current state (pre-clear value during a read).

Reset
REQ-029 While res_n=0, mask=0, flags=0, ir=0, delay stage=0 and irq_n=1, regardless of phi2_dn.
REQ-030 Reset asserted mid-cycle SHALL discard any pending read-clear or write.

Configuration
REQ-031 Macro CIA_ICR_DEBUG_EN: when defined, an extra output icr_mask[4:0] SHALL expose the mask register.
REQ-032 Without CIA_ICR_DEBUG_EN that port SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Package cia SHALL hold model_t (MOS6526, MOS8521) and icr_t (packed ir, 2 unused bits, 5 flag bits).
REQ-034 The block SHALL be a single module with no sub-module; edge detection of sources is external.

Verification
REQ-035 Reset, then read ICR -> regs=8'h00, irq_n=1.
REQ-036 MOS8521: write 8'h81, pulse sources=5'b00001 at cycle n -> regs=8'h81, irq_n=0 after cycle n; ICR read -> regs=8'h00, irq_n=1.
REQ-037 MOS6526: same stimulus as REQ-036 -> irq_n=1 after cycle n, irq_n=0 after cycle n+1.
REQ-038 Mask=0, pulse sources=5'b00010 -> regs=8'h02, irq_n=1; then write 8'h82 -> ir=1, irq_n low with model latency.
REQ-039 ICR read coinciding with sources=5'b10000 (mask 8'h90) -> read returns old value, afterwards regs=8'h90, irq_n=0.
REQ-040 Write 8'h9F then 8'h01 -> mask=5'b11110 (checked via icr_mask when CIA_ICR_DEBUG_EN is defined); res_n pulse mid-cycle -> all state zero, irq_n=1.
